sample_packer: RTL

Quantizes and bit-packs three-channel complex ADC samples into the 16-bit word stream that feeds the Ethernet packet buffer. It sits between the per-channel ADC capture/downconversion logic and the ping-pong frame buffer. It drives that buffer's `source_data`/`source_en` write port in the ADC clock domain. A selectable quantization depth (2, 4 or 8 bits per component) lets one link carry more or fewer bits per sample. A gearbox accumulator absorbs the mismatch between bits per sample and 16-bit words.

---
 rtl/sample_packer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sample_packer.sv
// sample_packer: quantizes six 8-bit complex ADC components to 2/4/8 bits
// and packs them MSB-first into a 16-bit word stream through a 64-bit
// gearbox accumulator.
// Optional feature: define PACKER_TEST_PATTERN_EN to build the test-pattern
// generator selected by test_mode; without it test_mode is ignored.
module sample_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic [47:0] samples,
   input  logic        sample_valid,
   input  logic [1:0]  mode,
   input  logic [6:0]  threshold,
   input  logic        test_mode,
   input  logic        clear_overflow,
   output logic [15:0] source_data,
   output logic        source_en,
   output logic        overflow,
   output logic [15:0] overflow_count
);

   typedef enum logic [1:0] {DEPTH_2, DEPTH_4, DEPTH_8} depth_e;

   function automatic depth_e depth_of(input logic [1:0] m);
      case (m)
         2'b00:   return DEPTH_2;
         2'b01:   return DEPTH_4;
         default: return DEPTH_8;
      endcase
   endfunction

   logic [1:0]  mode_q, mode_d;
   logic [47:0] s1_bits_q, s1_bits_d;
   logic        s1_valid_q, s1_valid_d;
   logic [63:0] acc_q, acc_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [15:0] source_data_q, source_data_d;
   logic        source_en_q, source_en_d;
   logic        overflow_q, overflow_d;
   logic [15:0] ovf_cnt_q, ovf_cnt_d;

   depth_e      depth;
   logic [6:0]  w;
   logic        mode_chg;
   logic [47:0] comp_in;
   logic [47:0] quant;
   logic [7:0]  x;
   logic [7:0]  mag;
   logic [6:0]  rem;
   logic [63:0] acc_rem;

   assign depth    = depth_of(mode_q);
   assign w        = (depth == DEPTH_2) ? 7'd12 : (depth == DEPTH_4) ? 7'd24 : 7'd48;
   assign mode_chg = (mode != mode_q);

`ifdef PACKER_TEST_PATTERN_EN
   logic [7:0] pat_q, pat_d;

   // Select live samples or the incrementing test pattern; advance the pattern counter per valid.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      comp_in = samples;
      pat_d   = pat_q;
      if (sample_valid) pat_d = pat_q + 8'd1;
      if (test_mode) begin
         for (int k = 0; k < 6; k++) begin
            comp_in[47-8*k -: 8] = pat_q + 8'(k);
         end
      end
   end

   // Pattern counter register.
   always_ff @(posedge clk) begin
      if (reset) pat_q <= 8'd0;
      else       pat_q <= pat_d;
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;

   // Live samples only; test_mode has no effect in this build.
   always_comb begin
      comp_in = samples;
   end
`endif

   // Quantize each component to the registered depth and pack left-aligned, ch0_i first.
   always_comb begin
      quant = '0;
      x     = '0;
      mag   = '0;
      for (int k = 0; k < 6; k++) begin
         x   = comp_in[47-8*k -: 8];
         mag = x[7] ? (~x + 8'd1) : x;   // -128 maps to 128 as unsigned
         case (depth)
            DEPTH_2: quant[47-2*k -: 2] = {x[7], (mag > {1'b0, threshold})};
            DEPTH_4: quant[47-4*k -: 4] = x[7:4];
            default: quant[47-8*k -: 8] = x;
         endcase
      end
   end

   // Gearbox: emit a word from the old count, then append or drop the stage-1 sample.
   always_comb begin
      mode_d        = mode;
      s1_valid_d    = sample_valid;
      s1_bits_d     = quant;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      source_en_d   = 1'b0;
      source_data_d = source_data_q;
      overflow_d    = overflow_q;
      ovf_cnt_d     = ovf_cnt_q;
      rem           = cnt_q;
      acc_rem       = acc_q;
      if (clear_overflow) overflow_d = 1'b0;
      if (mode_chg) begin
         // New depth: discard residual bits and the sample quantized under the old depth.
         s1_valid_d = 1'b0;
         acc_d      = '0;
         cnt_d      = 7'd0;
      end else begin
         if (cnt_q >= 7'd16) begin
            source_en_d   = 1'b1;
            source_data_d = acc_q[63:48];
            rem           = cnt_q - 7'd16;
            acc_rem       = acc_q << 16;
         end
         acc_d = acc_rem;
         cnt_d = rem;
         if (s1_valid_q) begin
            if (({1'b0, rem} + {1'b0, w}) <= 8'd64) begin
               acc_d = acc_rem | ({s1_bits_q, 16'h0000} >> rem);
               cnt_d = rem + w;
            end else begin
               overflow_d = 1'b1;
               if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
         end
      end
   end

   // State registers; stage-1 sample bits carry no reset since s1_valid qualifies them.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      // NOTE: pure datapath registers guarded by a valid bit are left without reset.
      s1_bits_q <= s1_bits_d;
      if (reset) begin
         mode_q        <= mode;
         s1_valid_q    <= 1'b0;
         acc_q         <= '0;
         cnt_q         <= 7'd0;
         source_data_q <= 16'h0000;
         source_en_q   <= 1'b0;
         overflow_q    <= 1'b0;
         ovf_cnt_q     <= 16'h0000;
      end else begin
         mode_q        <= mode_d;
         s1_valid_q    <= s1_valid_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         source_data_q <= source_data_d;
         source_en_q   <= source_en_d;
         overflow_q    <= overflow_d;
         ovf_cnt_q     <= ovf_cnt_d;
      end
   end

   assign source_data    = source_data_q;
   assign source_en      = source_en_q;
   assign overflow       = overflow_q;
   assign overflow_count = ovf_cnt_q;

endmodule
